// File: rtl/cpu6502_core.sv
// cpu6502_core: divided-clock 6502-subset core with loads, stores, transfers and INC/DEC.
// Optional build macro CPU_ILLEGAL_HALT_EN stops the core on undecoded opcodes.
module cpu6502_core #(
   parameter int unsigned CLOCK_DIVIDER = 12,
   parameter logic [15:0] RESET_VECTOR  = 16'hFFFC
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic [7:0]  data_i,
   input  logic        data_valid_i,
   output logic [7:0]  data_o,
   output logic [15:0] address_o,
   output logic        address_valid_o,
   output logic        data_valid_o,
   output logic        halted_o
);

   typedef enum logic [3:0] {
      VEC_LO, VEC_HI, FETCH, OPER1, OPER2, INDEX, READ, WRITE, EXEC, HALT
   } state_t;
   typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ZPI, M_ABS, M_ILL} mode_t;
   typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

   state_t      state_q;
   logic [7:0]  div_q, div_d;
   logic        tick, rd_step, step_en;
   logic [15:0] pc_q, pc_inc, address_q, mem_addr;
   logic [7:0]  a_q, x_q, y_q, status_q, op_q, base_q, data_q;
   logic        dv_q;
   logic [7:0]  dec_op, idx_val, st_val, imp_val, ld_val;
   mode_t       mode;
   reg_t        rsel, imp_reg, ld_reg;
   logic        is_store, idx_y, imp_en, ld_en, go_mem;

   assign tick    = (div_q == 8'(CLOCK_DIVIDER - 1));
   assign div_d   = tick ? '0 : div_q + 8'd1;
   assign rd_step = (state_q inside {VEC_LO, VEC_HI, FETCH, OPER1, OPER2, READ});
   assign step_en = tick && (!rd_step || data_valid_i);
   assign pc_inc  = pc_q + 16'd1;
   // Decode the byte on the bus during FETCH, the latched opcode afterwards.
   assign dec_op  = (state_q == FETCH) ? data_i : op_q;
   assign idx_val = idx_y ? y_q : x_q;

   always_comb begin
      mode     = M_ILL;
      rsel     = R_A;
      is_store = 1'b0;
      idx_y    = 1'b0;
      case (dec_op)
         8'hA9: mode = M_IMM;
         8'hA5: mode = M_ZP;
         8'hB5: mode = M_ZPI;
         8'hAD: mode = M_ABS;
         8'hA2: begin mode = M_IMM; rsel = R_X; end
         8'hA6: begin mode = M_ZP;  rsel = R_X; end
         8'hB6: begin mode = M_ZPI; rsel = R_X; idx_y = 1'b1; end
         8'hAE: begin mode = M_ABS; rsel = R_X; end
         8'hA0: begin mode = M_IMM; rsel = R_Y; end
         8'hA4: begin mode = M_ZP;  rsel = R_Y; end
         8'hB4: begin mode = M_ZPI; rsel = R_Y; end
         8'hAC: begin mode = M_ABS; rsel = R_Y; end
         8'h85: begin mode = M_ZP;  is_store = 1'b1; end
         8'h95: begin mode = M_ZPI; is_store = 1'b1; end
         8'h8D: begin mode = M_ABS; is_store = 1'b1; end
         8'h86: begin mode = M_ZP;  rsel = R_X; is_store = 1'b1; end
         8'h8E: begin mode = M_ABS; rsel = R_X; is_store = 1'b1; end
         8'h84: begin mode = M_ZP;  rsel = R_Y; is_store = 1'b1; end
         8'h8C: begin mode = M_ABS; rsel = R_Y; is_store = 1'b1; end
         8'hAA, 8'h8A, 8'hA8, 8'h98, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hEA: mode = M_IMP;
         default: mode = M_ILL;
      endcase
   end

   always_comb begin
      case (rsel)
         R_X:     st_val = x_q;
         R_Y:     st_val = y_q;
         default: st_val = a_q;
      endcase
   end

   always_comb begin
      imp_en  = 1'b1;
      imp_reg = R_X;
      imp_val = a_q;
      case (op_q)
         8'hAA: begin imp_reg = R_X; imp_val = a_q; end
         8'h8A: begin imp_reg = R_A; imp_val = x_q; end
         8'hA8: begin imp_reg = R_Y; imp_val = a_q; end
         8'h98: begin imp_reg = R_A; imp_val = y_q; end
         8'hE8: begin imp_reg = R_X; imp_val = x_q + 8'd1; end
         8'hC8: begin imp_reg = R_Y; imp_val = y_q + 8'd1; end
         8'hCA: begin imp_reg = R_X; imp_val = x_q - 8'd1; end
         8'h88: begin imp_reg = R_Y; imp_val = y_q - 8'd1; end
         default: imp_en = 1'b0;
      endcase
   end

   always_comb begin
      ld_en  = 1'b0;
      ld_reg = rsel;
      ld_val = data_i;
      case (state_q)
         OPER1: ld_en = (mode == M_IMM);
         READ:  ld_en = 1'b1;
         EXEC:  begin ld_en = imp_en; ld_reg = imp_reg; ld_val = imp_val; end
         default: ld_en = 1'b0;
      endcase
   end

   // Steps that put the effective address on the bus and branch to READ/WRITE.
   always_comb begin
      go_mem   = 1'b0;
      mem_addr = {data_i, base_q};
      case (state_q)
         OPER1: begin go_mem = (mode == M_ZP); mem_addr = {8'h00, data_i}; end
         OPER2: go_mem = 1'b1;
         INDEX: begin go_mem = 1'b1; mem_addr = {8'h00, 8'(base_q + idx_val)}; end
         default: go_mem = 1'b0;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= VEC_LO;
         div_q     <= '0;
         pc_q      <= '0;
         address_q <= RESET_VECTOR;
         a_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         status_q  <= 8'b0011_0100;
         op_q      <= '0;
         base_q    <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
      end else begin
         div_q <= div_d;
         if (step_en) begin
            if (ld_en) begin
               case (ld_reg)
                  R_X:     x_q <= ld_val;
                  R_Y:     y_q <= ld_val;
                  default: a_q <= ld_val;
               endcase
               status_q <= {ld_val[7], status_q[6:2], (ld_val == 8'h00), status_q[0]};
            end
            if (state_q inside {FETCH, OPER1, OPER2}) pc_q <= pc_inc;
            if (go_mem) begin
               address_q <= mem_addr;
               state_q   <= is_store ? WRITE : READ;
               dv_q      <= is_store;
               if (is_store) data_q <= st_val;
            end else begin
               case (state_q)
                  VEC_LO: begin
                     pc_q[7:0] <= data_i;
                     address_q <= RESET_VECTOR + 16'd1;
                     state_q   <= VEC_HI;
                  end
                  VEC_HI: begin
                     pc_q[15:8] <= data_i;
                     address_q  <= {data_i, pc_q[7:0]};
                     state_q    <= FETCH;
                  end
                  FETCH: begin
                     op_q      <= data_i;
                     address_q <= pc_inc;
                     case (mode)
                        M_IMP:   state_q <= EXEC;
`ifdef CPU_ILLEGAL_HALT_EN
                        M_ILL:   state_q <= HALT;
`else
                        M_ILL:   state_q <= EXEC;
`endif
                        default: state_q <= OPER1;
                     endcase
                  end
                  OPER1: begin
                     base_q    <= data_i;
                     address_q <= pc_inc;
                     state_q   <= (mode == M_IMM) ? FETCH : ((mode == M_ABS) ? OPER2 : INDEX);
                  end
                  READ, WRITE, EXEC: begin
                     address_q <= pc_q;
                     dv_q      <= 1'b0;
                     state_q   <= FETCH;
                  end
                  default: state_q <= state_q;
               endcase
            end
         end
      end
   end

   assign address_o       = address_q;
   assign data_o          = data_q;
   assign data_valid_o    = dv_q;
   assign address_valid_o = (state_q != HALT);
`ifdef CPU_ILLEGAL_HALT_EN
   assign halted_o        = (state_q == HALT);
`else
   assign halted_o        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu6502_core.sv
// Bench for cpu6502_core: random programs run through an instruction-level model; a monitor
// checks every bus write against the model's expected store queue.
module tb_cpu6502_core;

   localparam int unsigned D = 3;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clock_i = 1'b0;
   logic        reset_ni = 1'b1;
   logic [7:0]  data_i;
   logic        data_valid_i = 1'b1;
   logic [7:0]  data_o;
   logic [15:0] address_o;
   logic        address_valid_o;
   logic        data_valid_o;
   logic        halted_o;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  ra, rx, ry;
   int unsigned gpc;
   int          vectors = 0;
   int          miscompares = 0;
   logic        rand_valid = 1'b0;
   logic        dv_prev = 1'b0;
   int          hi_cnt = 0;

   logic [7:0] ops [28] = '{8'hA9, 8'hA5, 8'hB5, 8'hAD, 8'hA2, 8'hA6, 8'hB6, 8'hAE,
                            8'hA0, 8'hA4, 8'hB4, 8'hAC, 8'h85, 8'h95, 8'h8D, 8'h86,
                            8'h8E, 8'h84, 8'h8C, 8'hAA, 8'h8A, 8'hA8, 8'h98, 8'hE8,
                            8'hC8, 8'hCA, 8'h88, 8'hEA};

   cpu6502_core #(.CLOCK_DIVIDER(D), .RESET_VECTOR(16'hFFFC)) dut (
      .clock_i(clock_i),
      .reset_ni(reset_ni),
      .data_i(data_i),
      .data_valid_i(data_valid_i),
      .data_o(data_o),
      .address_o(address_o),
      .address_valid_o(address_valid_o),
      .data_valid_o(data_valid_o),
      .halted_o(halted_o)
   );

   always #5 clock_i = ~clock_i;

   assign data_i = mem[address_o];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One system clock: the memory side of the bus lives here.
   task automatic cyc();
      @(negedge clock_i);
      if (data_valid_o && address_valid_o) mem[address_o] = data_o;
      if (rand_valid) data_valid_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic put(input logic [7:0] b);
      mem[gpc[15:0]] = b;
      gpc = gpc + 1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      wr_t w;
      ref_mem[a] = d;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
   endtask

   // Places one instruction in memory and applies its architectural effect to the model.
   task automatic emit(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2);
      logic [15:0] zp, zx, zy, ab;
      zp = {8'h00, b1};
      zx = {8'h00, 8'(b1 + rx)};
      zy = {8'h00, 8'(b1 + ry)};
      ab = {b2, b1};
      put(op);
      case (op)
         8'hA9: begin put(b1); ra = b1; end
         8'hA5: begin put(b1); ra = ref_mem[zp]; end
         8'hB5: begin put(b1); ra = ref_mem[zx]; end
         8'hAD: begin put(b1); put(b2); ra = ref_mem[ab]; end
         8'hA2: begin put(b1); rx = b1; end
         8'hA6: begin put(b1); rx = ref_mem[zp]; end
         8'hB6: begin put(b1); rx = ref_mem[zy]; end
         8'hAE: begin put(b1); put(b2); rx = ref_mem[ab]; end
         8'hA0: begin put(b1); ry = b1; end
         8'hA4: begin put(b1); ry = ref_mem[zp]; end
         8'hB4: begin put(b1); ry = ref_mem[zx]; end
         8'hAC: begin put(b1); put(b2); ry = ref_mem[ab]; end
         8'h85: begin put(b1); wr(zp, ra); end
         8'h95: begin put(b1); wr(zx, ra); end
         8'h8D: begin put(b1); put(b2); wr(ab, ra); end
         8'h86: begin put(b1); wr(zp, rx); end
         8'h8E: begin put(b1); put(b2); wr(ab, rx); end
         8'h84: begin put(b1); wr(zp, ry); end
         8'h8C: begin put(b1); put(b2); wr(ab, ry); end
         8'hAA: rx = ra;
         8'h8A: ra = rx;
         8'hA8: ry = ra;
         8'h98: ra = ry;
         8'hE8: rx = rx + 8'd1;
         8'hC8: ry = ry + 8'd1;
         8'hCA: rx = rx - 8'd1;
         8'h88: ry = ry - 8'd1;
         default: ;
      endcase
   endtask

   always @(negedge clock_i) begin
      if (data_valid_o && !dv_prev) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: addr %h data %h, no store expected", address_o, data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (address_o !== mon_e.a || data_o !== mon_e.d || address_valid_o !== 1'b1) begin
               miscompares++;
               $display("FAIL store: got addr %h data %h av %b expected addr %h data %h av 1",
                        address_o, data_o, address_valid_o, mon_e.a, mon_e.d);
            end
         end
         hi_cnt = 1;
      end else if (data_valid_o) begin
         hi_cnt++;
      end else if (dv_prev && reset_ni) begin
         vectors++;
         if (hi_cnt != D) begin
            miscompares++;
            $display("FAIL strobe_len: got %0d clocks expected %0d", hi_cnt, D);
         end
      end
      dv_prev = data_valid_o;
   end

   initial begin
      int pick;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[16'h0010] = 8'h00;
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h80;
      for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
      ra = '0; rx = '0; ry = '0;
      gpc = 32'h8000;

      emit(8'hA2, 8'hF0, 8'h00);
      emit(8'hB5, 8'h20, 8'h00);
      emit(8'h8D, 8'h00, 8'h02);
      emit(8'hA9, 8'h80, 8'h00);
      emit(8'h85, 8'h10, 8'h00);
      emit(8'hA0, 8'hFF, 8'h00);
      emit(8'hC8, 8'h00, 8'h00);
      emit(8'h8C, 8'h00, 8'h03);
      emit(8'h88, 8'h00, 8'h00);
      emit(8'h8C, 8'h01, 8'h03);
      for (int n = 0; n < 150; n++) begin
`ifdef CPU_ILLEGAL_HALT_EN
         pick = $urandom_range(0, 27);
         emit(ops[pick], 8'($urandom), 8'($urandom_range(0, 3)));
`else
         pick = $urandom_range(0, 28);
         emit((pick == 28) ? 8'h02 : ops[pick], 8'($urandom), 8'($urandom_range(0, 3)));
`endif
      end
      emit(8'h8D, 8'h00, 8'h03);
      emit(8'h8E, 8'h01, 8'h03);
      emit(8'h8C, 8'h02, 8'h03);
`ifdef CPU_ILLEGAL_HALT_EN
      emit(8'h02, 8'h00, 8'h00);
`endif

      #1 reset_ni = 1'b0;
      repeat (3) cyc();
      chk("rst_addr", {16'h0, address_o}, 32'hFFFC);
      chk("rst_av", {31'h0, address_valid_o}, 32'h1);
      chk("rst_dv", {31'h0, data_valid_o}, 32'h0);
      chk("rst_data", {24'h0, data_o}, 32'h0);
      chk("rst_halt", {31'h0, halted_o}, 32'h0);
      reset_ni = 1'b1;

      repeat (D - 1) cyc();
      chk("div_no_tick", {16'h0, address_o}, 32'hFFFC);
      cyc();
      chk("vec_hi_addr", {16'h0, address_o}, 32'hFFFD);
      repeat (D) cyc();
      chk("first_fetch", {16'h0, address_o}, 32'h8000);
      repeat (D) cyc();
      chk("oper1_addr", {16'h0, address_o}, 32'h8001);
      data_valid_i = 1'b0;
      repeat (5 * D) cyc();
      chk("stall_frozen", {16'h0, address_o}, 32'h8001);
      rand_valid = 1'b1;

      for (int i = 0; i < 40000 && exp_q.size() != 0; i++) cyc();
      chk("drain", exp_q.size(), 0);
      repeat (20 * D) cyc();
`ifdef CPU_ILLEGAL_HALT_EN
      chk("halted", {31'h0, halted_o}, 32'h1);
      chk("halt_av", {31'h0, address_valid_o}, 32'h0);
`else
      chk("not_halted", {31'h0, halted_o}, 32'h0);
      chk("run_av", {31'h0, address_valid_o}, 32'h1);
`endif

      reset_ni = 1'b0;
      exp_q.delete();
      gpc = 32'h8000;
      ra = '0; rx = '0; ry = '0;
      emit(8'hA9, 8'h55, 8'h00);
      emit(8'h85, 8'h40, 8'h00);
      emit(8'hEA, 8'h00, 8'h00);
      repeat (2) cyc();
      reset_ni = 1'b1;
      for (int i = 0; i < 2000 && !data_valid_o; i++) cyc();
      chk("store_seen", {31'h0, data_valid_o}, 32'h1);
      #1 reset_ni = 1'b0;
      #1;
      chk("abort_dv", {31'h0, data_valid_o}, 32'h0);
      chk("abort_addr", {16'h0, address_o}, 32'hFFFC);
      chk("abort_av", {31'h0, address_valid_o}, 32'h1);
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
